sumofeven_seq: RTL and testbench
================================

Name: sumofeven_seq

Overview:
- Multi-cycle sequential engine computing S = sum of all even integers 2..N, inclusive of N when N is even.
- Built as an FSM controller that sequences an adder/step-counter datapath, one even term per clock.
- Start/busy/done handshake; result held until the next accepted start.
- Cycle-accurate companion to the combinational sum-of-evens unit: its S must match that unit for every N.

Parameters:
- W, 4, width of input N.
- SW, 7, width of result S; must satisfy SW >= 2*W-2 (max sum k*(k+1), k = floor((2^W-1)/2); 56 for W=4).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- N  input  W  operand; captured on the accepted start edge, ignored otherwise.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse, high in DONE.
- S  output  SW  result; valid from done high until the next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, S=0, internal n_reg=0, i=0.
- States: IDLE, RUN, DONE; binary encoded; all outputs registered or decoded from state only.
- IDLE:
  - start=1 at edge: n_reg<=N, acc<=0, i<=2, go RUN.
  - start=0: stay.
- RUN, each edge:
  - if i <= n_reg: acc <= acc+i, i <= i+2, stay.
  - else: go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- S is driven from acc. It clears to 0 on accepted start and is otherwise stable outside RUN.
- Step counter i is W+1 bits so it never wraps. For N=15, i reaches 16 and the compare terminates correctly.
- acc is SW bits; overflow is impossible under the SW constraint; no saturation logic.
- Latency: with k = floor(N/2), done is high in cycle k+2 after the start edge (1 RUN-entry edge, k add edges, 1 exit edge). Busy cycles = k+1.
- N=0 or N=1: zero adds; S=0, done at cycle 2.
- start asserted while busy or in DONE: ignored, no queueing; N changes during RUN have no effect.
- start held high continuously: a new computation is accepted on the first IDLE cycle after each DONE.
- Reset mid-RUN: abort immediately to the reset values; no done pulse; partial sum discarded.

Decomposition:
- Shared header: state encodings (ST_IDLE, ST_RUN, ST_DONE) and the default W/SW constants, `included by RTL and bench.
- Sub-module sumofeven_dp holds the datapath: n_reg, i counter, acc adder, and the i<=n_reg compare.
  - Inputs: load, step.
  - Outputs: more (i<=n_reg) and acc.
- Top holds the FSM and the handshake.

Test Plan:
- Reset, then start=1 for 1 cycle with N=10 -> busy for 6 cycles, done pulse at cycle 7, S=30 held afterwards.
- N=15 -> S=56, done at cycle 9, no wrap of i (i=16 terminates).
- N=0 and N=1 (separate runs) -> S=0, done at cycle 2, busy exactly 1 cycle.
- N=6 started, then start pulsed with N=2 mid-RUN -> ignored, S=12, single done pulse.
- N=14 started, rst asserted at cycle 3 -> busy/done/S drop to 0 asynchronously. Follow with start N=4 -> S=6.
- Sweep N=0..15 with start held high, compared against the combinational sum-of-evens unit -> every done S matches (0,0,2,2,6,6,12,12,20,20,30,30,42,42,56,56).

Source files
------------

// File: rtl/sumofeven_pkg.sv
// Shared constants and FSM state encoding for the sequential sum-of-evens engine.
package sumofeven_pkg;

    // Default operand and result widths; SW must be at least 2*W-2.
    localparam int W  = 4;
    localparam int SW = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sumofeven_dp.sv
// Datapath: captured operand, even step counter and accumulator.
// The step counter is one bit wider than N so that i = 16 is representable
// for N = 15 and the i <= n_reg compare terminates instead of wrapping.
module sumofeven_dp
    import sumofeven_pkg::*;
#(
    parameter int W  = sumofeven_pkg::W,
    parameter int SW = sumofeven_pkg::SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [W-1:0]  n_in,
    output logic          more,
    output logic [SW-1:0] acc
);

    logic [W-1:0] n_reg;
    logic [W:0]   i;

    // Load clears the sum and restarts at the first even term; step adds one term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg <= '0;
            i     <= '0;
            acc   <= '0;
        end else if (load) begin
            n_reg <= n_in;
            i     <= (W+1)'(2);
            acc   <= '0;
        end else if (step) begin
            i     <= i + (W+1)'(2);
            acc   <= acc + SW'(i);
        end
    end

    assign more = (i <= {1'b0, n_reg});

endmodule

// File: rtl/sumofeven_seq.sv
// Sequential sum-of-evens engine: S = 2 + 4 + ... up to N, one term per clock.
// Handshake: start is only sampled in IDLE; the edge that accepts it also
// captures N. busy is high for every RUN cycle, done pulses for one cycle, and
// S (the accumulator) stays valid from done until the next accepted start.
module sumofeven_seq
    import sumofeven_pkg::*;
#(
    parameter int W  = sumofeven_pkg::W,
    parameter int SW = sumofeven_pkg::SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  N,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] S,
    output logic [1:0]    state_dbg
);

    state_t state;
    logic   load;
    logic   step;
    logic   more;

    assign load      = (state == ST_IDLE) && start;
    assign step      = (state == ST_RUN) && more;
    assign state_dbg = state;

    sumofeven_dp #(.W(W), .SW(SW)) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .n_in (N),
        .more (more),
        .acc  (S)
    );

    // Controller: sequences the datapath and registers busy/done with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!more) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumofeven_seq.sv
// Bench for sumofeven_seq: table-driven single runs, a held-start sweep and
// hand-written sequences for mid-run start, mid-run reset.
module tb_sumofeven_seq;
    import sumofeven_pkg::*;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  N;
    logic          busy;
    logic          done;
    logic [SW-1:0] S;
    logic [1:0]    state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [W-1:0]  n;
        logic [SW-1:0] exp_s;
        int            exp_done_cyc;
        int            exp_busy;
    } vec_t;

    vec_t vecs[6];
    logic [SW-1:0] sweep_exp[16];

    sumofeven_seq #(.W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .N         (N),
        .busy      (busy),
        .done      (done),
        .S         (S),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Driver: one-cycle start pulse; N is scrambled afterwards to show it is not re-sampled.
    task automatic start_pulse(input logic [W-1:0] n);
        @(negedge clk);
        start = 1'b1;
        N     = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        N     = W'($urandom_range(0, 15));
    endtask

    // Counts cycles after the accepting edge until done, bounded.
    task automatic wait_done(output int dcyc, output int bcnt);
        dcyc = -1;
        bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcyc = c;
                break;
            end
        end
    endtask

    initial begin
        int dcyc, bcnt, dpulses;

        vecs[0] = '{n: 4'd10, exp_s: 7'd30, exp_done_cyc: 7, exp_busy: 6};
        vecs[1] = '{n: 4'd15, exp_s: 7'd56, exp_done_cyc: 9, exp_busy: 8};
        vecs[2] = '{n: 4'd0,  exp_s: 7'd0,  exp_done_cyc: 2, exp_busy: 1};
        vecs[3] = '{n: 4'd1,  exp_s: 7'd0,  exp_done_cyc: 2, exp_busy: 1};
        vecs[4] = '{n: 4'd2,  exp_s: 7'd2,  exp_done_cyc: 3, exp_busy: 2};
        vecs[5] = '{n: 4'd7,  exp_s: 7'd12, exp_done_cyc: 5, exp_busy: 4};

        sweep_exp = '{7'd0, 7'd0, 7'd2, 7'd2, 7'd6, 7'd6, 7'd12, 7'd12,
                      7'd20, 7'd20, 7'd30, 7'd30, 7'd42, 7'd42, 7'd56, 7'd56};

        start = 1'b0;
        N     = '0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_S", int'(S), 0);
        check("reset_state", int'(state_dbg), int'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single runs
        for (int v = 0; v < 6; v++) begin
            start_pulse(vecs[v].n);
            wait_done(dcyc, bcnt);
            check($sformatf("v%0d_done_cycle", v), dcyc, vecs[v].exp_done_cyc);
            check($sformatf("v%0d_busy_cycles", v), bcnt, vecs[v].exp_busy);
            check($sformatf("v%0d_S", v), int'(S), int'(vecs[v].exp_s));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse_end", v), int'(done), 0);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_S_held", v), int'(S), int'(vecs[v].exp_s));
        end

        // Start pulsed mid-RUN is ignored
        start_pulse(4'd6);
        dcyc    = -1;
        dpulses = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1;
                N     = 4'd2;
            end
            if (c == 3) start = 1'b0;
            if (done) begin
                dcyc = c;
                break;
            end
        end
        check("midstart_done_cycle", dcyc, 5);
        check("midstart_S", int'(S), 12);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dpulses++;
        end
        check("midstart_extra_done", dpulses, 0);
        check("midstart_S_held", int'(S), 12);

        // Reset mid-RUN aborts asynchronously
        start_pulse(4'd14);
        repeat (3) @(negedge clk);
        check("prereset_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_S", int'(S), 0);
        @(negedge clk);
        rst = 1'b0;
        start_pulse(4'd4);
        wait_done(dcyc, bcnt);
        check("postreset_done_cycle", dcyc, 4);
        check("postreset_S", int'(S), 6);
        @(negedge clk);

        // Sweep with start held high
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 16; n++) begin
            N = W'(n);
            @(posedge clk);
            #1;
            wait_done(dcyc, bcnt);
            check($sformatf("sweep%0d_done_cycle", n), dcyc, n / 2 + 2);
            check($sformatf("sweep%0d_S", n), int'(S), int'(sweep_exp[n]));
            @(negedge clk);
            check($sformatf("sweep%0d_idle", n), int'(state_dbg), int'(ST_IDLE));
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
